// File: rtl/keypad_encoder_pkg.sv
// Shared types for the keypad encoder: controller key codes, scan FSM states,
// and the combinational row/column to key-code map.
package keypad_encoder_pkg;

  localparam int IC_N    = 5;
  localparam int KE_N    = 4;
  localparam int KP_ROWS = 5;
  localparam int KP_COLS = 4;

  typedef enum logic [IC_N-1:0] {
    IC_NONE, IC_0, IC_1, IC_2, IC_3, IC_4, IC_5, IC_6, IC_7, IC_8, IC_9,
    IC_AD, IC_SB, IC_MU, IC_DI, IC_LP, IC_RP, IC_CLCL, IC_CLBK, IC_OK
  } ic_t;

  typedef enum logic [$clog2(KE_N)-1:0] {
    KE_SCAN, KE_DEBOUNCE, KE_PRESENT, KE_RELEASE
  } ke_t;

  typedef struct packed {
    logic vld;
    ic_t  code;
  } kmap_t;

  function automatic kmap_t key_map(input logic [2:0] row, input logic [1:0] col);
    kmap_t m;
    m = '{vld: 1'b1, code: IC_NONE};
    case ({row, col})
      5'd0:  m.code = IC_7;
      5'd1:  m.code = IC_8;
      5'd2:  m.code = IC_9;
      5'd3:  m.code = IC_DI;
      5'd4:  m.code = IC_4;
      5'd5:  m.code = IC_5;
      5'd6:  m.code = IC_6;
      5'd7:  m.code = IC_MU;
      5'd8:  m.code = IC_1;
      5'd9:  m.code = IC_2;
      5'd10: m.code = IC_3;
      5'd11: m.code = IC_SB;
      5'd12: m.code = IC_0;
      5'd13: m.code = IC_LP;
      5'd14: m.code = IC_RP;
      5'd15: m.code = IC_AD;
      5'd16: m.code = IC_CLCL;
      5'd17: m.code = IC_CLBK;
      5'd18: m.code = IC_OK;
      default: m.vld = 1'b0;  // r4c3 is reserved, plus unreachable encodings
    endcase
    return m;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad matrix lines plus the in_cmd/in_ack link to the calculator controller.
interface keypad_encoder_if;
  import keypad_encoder_pkg::*;

  logic [KP_ROWS-1:0] kp_row;
  logic [KP_COLS-1:0] kp_col;
  ic_t                in_cmd;
  logic               in_ack;

  modport master (output kp_row, output in_cmd, input kp_col, input in_ack);
  modport slave  (input kp_row, input in_cmd, output kp_col, output in_ack);
endinterface

// File: rtl/keypad_encoder_kp_sync.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read as released.
module kp_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/keypad_encoder.sv
// Row-scanning keypad encoder: debounces one key at a time and presents its code
// on in_cmd until the controller acknowledges it, then waits for a full release.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input logic              clk_i,
  input logic              rst_ni,
  keypad_encoder_if.master bus
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE);

  ke_t                state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KP_ROWS-1:0] row_q, row_d;
  logic [1:0]         kcol_q, kcol_d;
  ic_t                cmd_q, cmd_d;

  logic [KP_COLS-1:0] col_s, low, kmask;
  logic [KP_ROWS-1:0] rot;
  logic [CW-1:0]      cnt_inc;
  logic [2:0]         ridx;
  logic [1:0]         lidx;
  logic               sample, one_low;
  kmap_t              kmap;

  kp_sync #(.W(KP_COLS)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.kp_col),
    .q_o    (col_s)
  );

  assign sample  = (div_q == DIV_LAST);
  assign low     = ~col_s;
  assign one_low = (low != '0) && ((low & (low - 1'b1)) == '0);
  assign kmask   = ~(KP_COLS'(1) << kcol_q);
  assign rot     = {row_q[KP_ROWS-2:0], row_q[KP_ROWS-1]};
  assign cnt_inc = (cnt_q == DB_LAST) ? cnt_q : cnt_q + 1'b1;
  assign kmap    = key_map(ridx, kcol_q);

  always_comb begin
    ridx = '0;
    lidx = '0;
    for (int i = 0; i < KP_ROWS; i++) if (!row_q[i]) ridx = 3'(i);
    for (int i = 0; i < KP_COLS; i++) if (low[i]) lidx = 2'(i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= KE_SCAN;
      div_q   <= '0;
      cnt_q   <= '0;
      row_q   <= 5'b11110;
      kcol_q  <= '0;
      cmd_q   <= IC_NONE;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      kcol_q  <= kcol_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = sample ? '0 : div_q + 1'b1;
    cnt_d   = cnt_q;
    row_d   = row_q;
    kcol_d  = kcol_q;
    cmd_d   = cmd_q;
    case (state_q)
      KE_SCAN: if (sample) begin
        // Multiple lows are ghosting and are treated like an empty row.
        if (one_low) begin
          kcol_d  = lidx;
          cnt_d   = CW'(1);
          state_d = KE_DEBOUNCE;
        end else begin
          row_d = rot;
        end
      end
      KE_DEBOUNCE: if (sample) begin
        if (col_s == kmask) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) begin
            cnt_d = '0;
            if (kmap.vld) begin
              cmd_d   = kmap.code;
              state_d = KE_PRESENT;
            end else begin
              state_d = KE_RELEASE;
            end
          end
        end else begin
          cnt_d   = '0;
          state_d = KE_SCAN;
        end
      end
      KE_PRESENT: if (bus.in_ack) begin
        cmd_d   = IC_NONE;
        state_d = KE_RELEASE;
      end
      KE_RELEASE: if (sample) begin
        if (col_s == '1) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LAST) begin
            cnt_d   = '0;
            row_d   = rot;
            state_d = KE_SCAN;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = KE_SCAN;
    endcase
  end

  assign bus.kp_row = row_q;
  assign bus.in_cmd = cmd_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Scoreboarded bench: scripted and random key presses on a modelled 5x4 matrix;
// expected codes queued at press time, popped when the encoder presents a code.
module tb_keypad_encoder;
  import keypad_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_encoder_if bus ();

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Matrix model: a pressed key pulls its column low while its row is driven low.
  bit pressed [5][4];
  logic [3:0] col_w;
  always_comb begin
    col_w = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 5; r++)
        if (pressed[r][c] && !bus.kp_row[r]) col_w[c] = 1'b0;
  end
  assign bus.kp_col = col_w;

  ic_t kmap_tb [20] = '{IC_7, IC_8, IC_9, IC_DI,
                        IC_4, IC_5, IC_6, IC_MU,
                        IC_1, IC_2, IC_3, IC_SB,
                        IC_0, IC_LP, IC_RP, IC_AD,
                        IC_CLCL, IC_CLBK, IC_OK, IC_NONE};

  int  vectors = 0;
  int  miscompares = 0;
  ic_t exp_q [$];
  bit  ack_en = 1'b1;
  int  ack_dly = -1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] row_exp(input int i);
    return ~(5'b00001 << i);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
  endtask

  task automatic press(input int r, input int c, input int hold);
    if (kmap_tb[r*4+c] != IC_NONE) exp_q.push_back(kmap_tb[r*4+c]);
    pressed[r][c] = 1'b1;
    idle(hold);
    pressed[r][c] = 1'b0;
  endtask

  // Monitor: owns in_ack, checks each presented code, its stability and its retirement.
  initial begin : monitor
    ic_t prev;
    bit  ack_pend;
    int  wait_n;
    prev = IC_NONE;
    ack_pend = 1'b0;
    wait_n = 0;
    bus.in_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = IC_NONE;
        ack_pend = 1'b0;
        bus.in_ack = 1'b0;
      end else if (ack_pend) begin
        bus.in_ack = 1'b0;
        ack_pend = 1'b0;
        chk("ack_retire", int'(bus.in_cmd), int'(IC_NONE));
        prev = bus.in_cmd;
      end else if (bus.in_cmd != IC_NONE) begin
        bus.in_ack = 1'b0;
        if (prev == IC_NONE) begin
          if (exp_q.size() == 0) chk("unexpected_code", int'(bus.in_cmd), int'(IC_NONE));
          else chk("code", int'(bus.in_cmd), int'(exp_q.pop_front()));
          wait_n = (ack_dly >= 0) ? ack_dly : $urandom_range(0, 5);
        end else begin
          chk("code_stable", int'(bus.in_cmd), int'(prev));
        end
        if (ack_en) begin
          if (wait_n == 0) begin
            bus.in_ack = 1'b1;
            ack_pend = 1'b1;
          end else begin
            wait_n--;
          end
        end
        prev = bus.in_cmd;
      end else begin
        // Stray acks while nothing is presented must be ignored by the encoder.
        bus.in_ack = ($urandom_range(0, 7) == 0);
        prev = bus.in_cmd;
      end
    end
  end

  initial begin : stim
    int k, waited;
    clear_keys();
    idle(3);
    chk("reset_row", int'(bus.kp_row), int'(5'b11110));
    chk("reset_cmd", int'(bus.in_cmd), int'(IC_NONE));
    rst_n = 1'b1;

    // Idle scan: one row step every 4 clocks starting from r0.
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      chk("scan_row", int'(bus.kp_row), int'(row_exp((n / 4) % 5)));
      chk("scan_cmd", int'(bus.in_cmd), int'(IC_NONE));
    end

    ack_dly = 5;
    press(2, 1, 40);
    ack_dly = -1;
    idle(30);

    // Bounce on r0c3, one toggle per sample period, then a stable press.
    for (int n = 0; n < 8; n++) begin
      pressed[0][3] = ~pressed[0][3];
      idle(4);
    end
    pressed[0][3] = 1'b0;
    press(0, 3, 40);
    idle(30);

    // Reserved key: no code, row held until the release is debounced.
    press(4, 3, 40);
    pressed[4][3] = 1'b1;
    idle(0);
    pressed[4][3] = 1'b0;
    chk("resv_row_held", int'(bus.kp_row), int'(5'b01111));
    idle(6);
    chk("resv_row_after", int'(bus.kp_row), int'(5'b01111));
    idle(30);

    // Second key while the first is held yields nothing until a fresh press.
    exp_q.push_back(IC_AD);
    pressed[3][3] = 1'b1;
    idle(50);
    pressed[1][0] = 1'b1;
    idle(30);
    clear_keys();
    idle(30);
    press(1, 0, 40);
    idle(30);

    // Reset while a code is presented: dropped at once, never replayed.
    ack_en = 1'b0;
    exp_q.push_back(IC_OK);
    pressed[4][2] = 1'b1;
    waited = 0;
    while (bus.in_cmd == IC_NONE && waited < 100) begin
      idle(1);
      waited++;
    end
    chk("ok_presented", int'(bus.in_cmd), int'(IC_OK));
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", int'(bus.in_cmd), int'(IC_NONE));
    chk("async_rst_row", int'(bus.kp_row), int'(5'b11110));
    clear_keys();
    idle(2);
    rst_n = 1'b1;
    ack_en = 1'b1;
    idle(60);

    // Ghost: two keys in one row are ignored; releasing one leaves a valid press.
    pressed[1][1] = 1'b1;
    pressed[1][2] = 1'b1;
    idle(40);
    k = $urandom_range(1, 2);
    pressed[1][3-k] = 1'b0;
    exp_q.push_back(k == 1 ? IC_5 : IC_6);
    idle(40);
    clear_keys();
    idle(30);

    for (int n = 0; n < 10; n++) begin
      press($urandom_range(0, 4), $urandom_range(0, 3), 40 + $urandom_range(0, 10));
      idle(30 + $urandom_range(0, 10));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
